// File: rtl/fixed_matmul_pkg.sv
// Shared types and sizing helper for the matmul tile gather block.
package fixed_matmul_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } gather_state_t;

  // Number of elements in one gathered row block.
  function automatic int out_elems(input int p1, input int p2, input int n);
    return p1 * p2 * n;
  endfunction

endpackage

// File: rtl/fixed_matmul_tile_gather_bank.sv
// One row-block bank: register array written one tile column at a time,
// plus a full flag marking a completed block awaiting drain.
module tile_gather_bank
  import fixed_matmul_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int IN1_PARALLELISM     = 4,
  parameter int IN2_PARALLELISM     = 4,
  parameter int IN2_NUM_PARALLELISM = 2,
  localparam int TILE_N = IN1_PARALLELISM * IN2_PARALLELISM,
  localparam int OUT_N  = out_elems(IN1_PARALLELISM, IN2_PARALLELISM, IN2_NUM_PARALLELISM),
  localparam int CW     = (IN2_NUM_PARALLELISM > 1) ? $clog2(IN2_NUM_PARALLELISM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [CW-1:0]                      wr_col,
  input  logic [TILE_N-1:0][DATA_WIDTH-1:0]  tile,
  input  logic                               set_full,
  input  logic                               clr_full,
  output logic [OUT_N-1:0][DATA_WIDTH-1:0]   data,
  output logic                               full
);

  localparam int ROW = IN2_PARALLELISM * IN2_NUM_PARALLELISM;

  logic [IN2_NUM_PARALLELISM-1:0] col_we;

  // Decode which tile column this write lands in.
  always_comb begin
    col_we = '0;
    for (int j = 0; j < IN2_NUM_PARALLELISM; j++)
      col_we[j] = wr_en && (int'(wr_col) == j);
  end

  // Scatter each tile row into its slot of the wide output row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else begin
      for (int j = 0; j < IN2_NUM_PARALLELISM; j++)
        for (int r = 0; r < IN1_PARALLELISM; r++)
          for (int c = 0; c < IN2_PARALLELISM; c++)
            if (col_we[j])
              data[r*ROW + j*IN2_PARALLELISM + c] <= tile[r*IN2_PARALLELISM + c];
    end
  end

  // Full once the last column lands, empty again after the drain handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          full <= 1'b0;
    else if (set_full) full <= 1'b1;
    else if (clr_full) full <= 1'b0;
  end

endmodule

// File: rtl/fixed_matmul_tile_gather.sv
// Gathers IN2_NUM_PARALLELISM matmul output tiles into one row block.
// Define FIXED_MATMUL_TILE_GATHER_DBUF_EN for two ping-pong banks, which lets
// the next block fill while the previous one waits to drain.
module fixed_matmul_tile_gather
  import fixed_matmul_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int IN1_PARALLELISM     = 4,
  parameter int IN2_PARALLELISM     = 4,
  parameter int IN2_NUM_PARALLELISM = 2,
  localparam int TILE_N = IN1_PARALLELISM * IN2_PARALLELISM,
  localparam int OUT_N  = out_elems(IN1_PARALLELISM, IN2_PARALLELISM, IN2_NUM_PARALLELISM),
  localparam int CW     = (IN2_NUM_PARALLELISM > 1) ? $clog2(IN2_NUM_PARALLELISM) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TILE_N-1:0][DATA_WIDTH-1:0] data_in,
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  output logic [OUT_N-1:0][DATA_WIDTH-1:0]  data_out,
  output logic                              data_out_valid,
  input  logic                              data_out_ready
);

`ifdef FIXED_MATMUL_TILE_GATHER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  gather_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept, last, drain;
  logic [NB-1:0] full, wr_hit, rd_hit;
  logic [NB-1:0][OUT_N-1:0][DATA_WIDTH-1:0] bank_data;

  assign data_in_ready = (state == FILL);
  assign accept        = data_in_valid && data_in_ready;
  assign drain         = data_out_valid && data_out_ready;
  assign last          = (int'(cnt) == IN2_NUM_PARALLELISM - 1);

`ifdef FIXED_MATMUL_TILE_GATHER_DBUF_EN
  logic wr_sel, rd_sel;

  assign wr_hit         = {wr_sel, ~wr_sel};
  assign rd_hit         = {rd_sel, ~rd_sel};
  assign data_out       = bank_data[rd_sel];
  assign data_out_valid = full[rd_sel];

  // Ping-pong pointers: write flips per completed block, read per drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (accept && last) wr_sel <= ~wr_sel;
      if (drain)          rd_sel <= ~rd_sel;
    end
  end
`else
  assign wr_hit         = 1'b1;
  assign rd_hit         = 1'b1;
  assign data_out       = bank_data[0];
  assign data_out_valid = full[0];
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    tile_gather_bank #(
      .DATA_WIDTH         (DATA_WIDTH),
      .IN1_PARALLELISM    (IN1_PARALLELISM),
      .IN2_PARALLELISM    (IN2_PARALLELISM),
      .IN2_NUM_PARALLELISM(IN2_NUM_PARALLELISM)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && wr_hit[b]),
      .wr_col  (cnt),
      .tile    (data_in),
      .set_full(accept && last && wr_hit[b]),
      .clr_full(drain && rd_hit[b]),
      .data    (bank_data[b]),
      .full    (full[b])
    );
  end

  // State register and tile column counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Stall input only while the bank to be written still holds an undrained block.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && last) begin
`ifdef FIXED_MATMUL_TILE_GATHER_DBUF_EN
        // Next write bank is the other one; stall only if it is still full.
        if (full[~wr_sel] && !drain) state_nxt = DRAIN;
`else
        state_nxt = DRAIN;
`endif
      end
      DRAIN: if (drain) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

endmodule

// File: doc/fixed_matmul_tile_gather.md
FIXED_MATMUL_TILE_GATHER -- requirements
Module: fixed_matmul_tile_gather

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of each output element.
REQ-002 SHALL have parameter IN1_PARALLELISM, default 4, the number of tile rows.
REQ-003 SHALL have parameter IN2_PARALLELISM, default 4, the number of tile columns.
REQ-004 SHALL have parameter IN2_NUM_PARALLELISM, default 2, the number of tiles per row block (legal range 1 or more).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port data_in, input, DATA_WIDTH x (IN1_PARALLELISM*IN2_PARALLELISM): the matmul output tile; element [r*IN2_PARALLELISM+c] is row r, column c.
REQ-008 SHALL have ports data_in_valid (input, 1 bit) and data_in_ready (output, 1 bit): the tile handshake.
REQ-009 SHALL have port data_out, output, DATA_WIDTH x (IN1_PARALLELISM*IN2_PARALLELISM*IN2_NUM_PARALLELISM): the gathered row block.
REQ-010 SHALL have ports data_out_valid (output, 1 bit) and data_out_ready (input, 1 bit): the row-block handshake.

Function
REQ-011 A transfer SHALL occur only on a clock edge where valid and ready are both 1; data_out and data_out_valid SHALL be registered.
REQ-012 Tiles SHALL arrive in order j = 0 .. IN2_NUM_PARALLELISM-1, where j is the column-block index of the matmul output order.
REQ-013 The element at row r, column c of accepted tile j SHALL be stored at data_out[r*(IN2_PARALLELISM*IN2_NUM_PARALLELISM) + j*IN2_PARALLELISM + c].
REQ-014 The block SHALL implement FSM states FILL and DRAIN.
REQ-015 In FILL: data_in_ready = 1; each accepted tile increments the tile counter; accepting tile j = IN2_NUM_PARALLELISM-1 SHALL move the FSM to DRAIN and wrap the counter to 0.
REQ-016 In DRAIN: data_in_ready = 0 and data_out_valid = 1; data_out SHALL hold stable until data_out_ready = 1, after which the FSM SHALL return to FILL.
REQ-017 data_out_valid SHALL rise exactly 1 cycle after acceptance of the last tile.
REQ-018 Single-bank throughput SHALL be one row block per IN2_NUM_PARALLELISM+1 cycles when data_out_ready is held at 1.
REQ-019 With IN2_NUM_PARALLELISM = 1, every tile SHALL pass through with 1-cycle latency and alternate FILL/DRAIN.
REQ-020 Data values SHALL be copied bit-exact, with no arithmetic, rounding, or sign handling.

Reset
REQ-021 While rst = 0, the block SHALL set: state FILL, tile counter 0, data_out_valid 0, every data_out element 0, and all bank valid flags 0.
REQ-022 Reset asserted mid-fill SHALL discard the partial row block; the first tile accepted after deassertion SHALL be j = 0.
REQ-023 No transfer SHALL be recorded in a cycle where rst = 0.

Configuration
REQ-024 Macro FIXED_MATMUL_TILE_GATHER_DBUF_EN, when defined, SHALL instantiate two banks used ping-pong.
REQ-025 With the macro defined, data_in_ready SHALL be 0 only when the write bank is still awaiting drain.
REQ-026 With the macro defined, the last tile of block k+1 and the drain of block k MAY occur in the same cycle.
REQ-027 With the macro defined, throughput SHALL be one row block per IN2_NUM_PARALLELISM cycles when data_out_ready is held at 1.
REQ-028 With the macro defined, output order SHALL equal input order.
REQ-029 Without the macro, the block SHALL behave exactly per REQ-014..REQ-019 with one bank.

Structure
REQ-030 A shared package fixed_matmul_pkg SHALL hold the FSM state enum (FILL, DRAIN) and a function returning the output element count IN1_PARALLELISM*IN2_PARALLELISM*IN2_NUM_PARALLELISM.
REQ-031 Sub-module tile_gather_bank SHALL hold one bank's register array with per-tile-column write enable and a full flag; the top level SHALL instantiate it once, or twice under the macro.

Verification
REQ-032 Defaults, tiles with element value = 100*j + index, j = 0..1, data_out_ready = 1 -> data_out_valid high for 1 cycle, 1 cycle after the second tile; data_out[0..3] = 0..3, data_out[4..7] = 100..103, data_out[8] = 4.
REQ-033 Hold data_out_ready = 0 for 5 cycles while in DRAIN -> data_out stable, data_in_ready = 0 throughout; a third tile presented is accepted only after drain.
REQ-034 Assert rst after tile 0 of a block -> all outputs 0; a new block j = 0, 1 afterwards yields only new values.
REQ-035 IN2_NUM_PARALLELISM = 1, 4 back-to-back tiles -> 4 row blocks, each equal to its input tile, emitted 1 cycle after acceptance.
REQ-036 DBUF_EN defined, continuous valid and ready, 8 tiles -> 4 row blocks in 8 cycles plus 1 latency cycle, data_in_ready never 0.
